// File: rtl/prog_pkg.sv
// Shared constants and state encoding for the UART-driven memory programmer.
package prog_pkg;

    localparam logic [7:0] CMD_READ    = 8'h72;
    localparam logic [7:0] CMD_WRITE   = 8'h77;
    localparam logic [7:0] CMD_INC     = 8'h6E;

    localparam logic [7:0] RSP_UNKNOWN = 8'h3F;
    localparam logic [7:0] RSP_TIMEOUT = 8'h21;
    localparam logic [7:0] RSP_WR_OK   = CMD_WRITE;

    localparam logic [7:0] ACK_TIMEOUT = 8'd255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADR2,
        ST_ADR1,
        ST_ADR0,
        ST_DHI,
        ST_DLO,
        ST_REQ,
        ST_RSP
    } state_t;

endpackage

// File: rtl/prog_rsp_tx.sv
// Response byte queue (depth 2) feeding the UART transmitter; launches a byte
// when tx_rdy is high, then holds off for the pulse cycle plus one more.
module prog_rsp_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic       two_i,
    input  logic [7:0] byte0_i,
    input  logic [7:0] byte1_i,
    input  logic       tx_rdy_i,
    output logic       tx_new_o,
    output logic [7:0] tx_char_o,
    output logic       last_o
);

    logic [1:0] cnt_q, cnt_d;
    logic [7:0] buf0_q, buf0_d;
    logic [7:0] buf1_q, buf1_d;
    logic       new_q, new_d;
    logic [7:0] char_q, char_d;
    logic       hold_q, hold_d;
    logic       launch;

    // A push only ever arrives while the queue is empty, so it never races a launch.
    always_comb begin
        cnt_d  = cnt_q;
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        char_d = char_q;
        new_d  = 1'b0;
        hold_d = new_q;
        launch = (cnt_q != 2'd0) && tx_rdy_i && !new_q && !hold_q;
        if (push_i) begin
            buf0_d = byte0_i;
            buf1_d = byte1_i;
            cnt_d  = two_i ? 2'd2 : 2'd1;
        end else if (launch) begin
            new_d  = 1'b1;
            char_d = buf0_q;
            buf0_d = buf1_q;
            cnt_d  = cnt_q - 2'd1;
        end
        last_o = launch && (cnt_q == 2'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= 2'd0;
            buf0_q <= 8'd0;
            buf1_q <= 8'd0;
            new_q  <= 1'b0;
            char_q <= 8'd0;
            hold_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            buf0_q <= buf0_d;
            buf1_q <= buf1_d;
            new_q  <= new_d;
            char_q <= char_d;
            hold_q <= hold_d;
        end
    end

    assign tx_new_o  = new_q;
    assign tx_char_o = char_q;

endmodule

// File: rtl/prog_seq.sv
// Command sequencer: decodes UART read/write commands into single memory
// requests and returns response bytes. PROG_SEQ_AUTOINC_EN adds the 'n' command.
module prog_seq
    import prog_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_new,
    input  logic        tx_rdy,
    output logic        tx_new,
    output logic [7:0]  tx_char,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic        mem_rw,
    output logic [19:0] mem_adr,
    output logic [15:0] mem_dtw,
    input  logic [15:0] mem_dtr,
    output logic        busy
);

    state_t      state_q, state_d;
    logic [19:0] adr_q, adr_d;
    logic [15:0] dtw_q, dtw_d;
    logic        rw_q, rw_d;
    logic        req_q, req_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        push;
    logic        two;
    logic [7:0]  rsp0;
    logic [7:0]  rsp1;
    logic        rsp_done;
`ifdef PROG_SEQ_AUTOINC_EN
    logic [19:0] last_q, last_d;
`endif

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dtw_d   = dtw_q;
        rw_d    = rw_q;
        req_d   = req_q;
        tmo_d   = tmo_q;
        push    = 1'b0;
        two     = 1'b0;
        rsp0    = 8'd0;
        rsp1    = 8'd0;
`ifdef PROG_SEQ_AUTOINC_EN
        last_d  = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rx_new) begin
                    case (rx_data)
                        CMD_READ: begin
                            rw_d    = 1'b0;
                            state_d = ST_ADR2;
                        end
                        CMD_WRITE: begin
                            rw_d    = 1'b1;
                            state_d = ST_ADR2;
                        end
`ifdef PROG_SEQ_AUTOINC_EN
                        CMD_INC: begin
                            rw_d    = 1'b1;
                            adr_d   = last_q + 20'd1;
                            state_d = ST_DHI;
                        end
`endif
                        default: begin
                            push    = 1'b1;
                            rsp0    = RSP_UNKNOWN;
                            state_d = ST_RSP;
                        end
                    endcase
                end
            end
            ST_ADR2: if (rx_new) begin
                adr_d[19:16] = rx_data[3:0];
                state_d      = ST_ADR1;
            end
            ST_ADR1: if (rx_new) begin
                adr_d[15:8] = rx_data;
                state_d     = ST_ADR0;
            end
            ST_ADR0: if (rx_new) begin
                adr_d[7:0] = rx_data;
                state_d    = rw_q ? ST_DHI : ST_REQ;
            end
            ST_DHI: if (rx_new) begin
                dtw_d[15:8] = rx_data;
                state_d     = ST_DLO;
            end
            ST_DLO: if (rx_new) begin
                dtw_d[7:0] = rx_data;
                state_d    = ST_REQ;
            end
            ST_REQ: begin
                // First REQ cycle raises the request; ack is checked before the timeout.
                if (!req_q) begin
                    req_d = 1'b1;
                    tmo_d = 8'd0;
                end else if (mem_ack) begin
                    req_d   = 1'b0;
                    tmo_d   = 8'd0;
                    push    = 1'b1;
                    state_d = ST_RSP;
`ifdef PROG_SEQ_AUTOINC_EN
                    last_d  = adr_q;
`endif
                    if (rw_q) begin
                        rsp0 = RSP_WR_OK;
                    end else begin
                        two  = 1'b1;
                        rsp0 = mem_dtr[15:8];
                        rsp1 = mem_dtr[7:0];
                    end
                end else if (tmo_q == ACK_TIMEOUT - 8'd1) begin
                    req_d   = 1'b0;
                    tmo_d   = 8'd0;
                    push    = 1'b1;
                    rsp0    = RSP_TIMEOUT;
                    state_d = ST_RSP;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ST_RSP: if (rsp_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            adr_q   <= 20'd0;
            dtw_q   <= 16'd0;
            rw_q    <= 1'b0;
            req_q   <= 1'b0;
            tmo_q   <= 8'd0;
`ifdef PROG_SEQ_AUTOINC_EN
            last_q  <= 20'd0;
`endif
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dtw_q   <= dtw_d;
            rw_q    <= rw_d;
            req_q   <= req_d;
            tmo_q   <= tmo_d;
`ifdef PROG_SEQ_AUTOINC_EN
            last_q  <= last_d;
`endif
        end
    end

    prog_rsp_tx u_rsp_tx (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push),
        .two_i     (two),
        .byte0_i   (rsp0),
        .byte1_i   (rsp1),
        .tx_rdy_i  (tx_rdy),
        .tx_new_o  (tx_new),
        .tx_char_o (tx_char),
        .last_o    (rsp_done)
    );

    assign mem_req = req_q;
    assign mem_rw  = rw_q;
    assign mem_adr = adr_q;
    assign mem_dtw = dtw_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_prog_seq.sv
// Scoreboard bench for prog_seq: stimulus pushes expected memory requests and
// response bytes; independent monitors pop and compare.
module tb_prog_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_new = 1'b0;
    logic        tx_rdy = 1'b0;
    logic        tx_new;
    logic [7:0]  tx_char;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic        mem_rw;
    logic [19:0] mem_adr;
    logic [15:0] mem_dtw;
    logic [15:0] mem_dtr = 16'd0;
    logic        busy;

    prog_seq dut (
        .clk     (clk),
        .rst     (rst),
        .rx_data (rx_data),
        .rx_new  (rx_new),
        .tx_rdy  (tx_rdy),
        .tx_new  (tx_new),
        .tx_char (tx_char),
        .mem_req (mem_req),
        .mem_ack (mem_ack),
        .mem_rw  (mem_rw),
        .mem_adr (mem_adr),
        .mem_dtw (mem_dtw),
        .mem_dtr (mem_dtr),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rw;
        logic [19:0] adr;
        logic [15:0] dtw;
    } mreq_t;

    mreq_t       exp_mem[$];
    logic [7:0]  exp_tx[$];
    logic [19:0] mdl_last = 20'd0;

    int checks = 0;
    int errors = 0;

    int          ack_delay = 1;
    logic [15:0] rd_val = 16'd0;
    bit          force_ack = 0;
    bit          skip_hi = 0;
    bit          tx_hold = 0;
    int          tx_seen = 0;

    // Transmit side: checks each launched byte, launch legality, and spacing; drives tx_rdy.
    int cyc = 0;
    int last_pulse = -100;
    always @(negedge clk) begin
        cyc++;
        if (tx_new) begin
            tx_seen++;
            checks++;
            if (tx_rdy !== 1'b1 || (cyc - last_pulse) <= 2) begin
                errors++;
                $display("FAIL tx_launch got rdy=%0b gap=%0d required rdy=1 gap>2", tx_rdy, cyc - last_pulse);
            end
            last_pulse = cyc;
            checks++;
            if (exp_tx.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected got %02h required none", tx_char);
            end else begin
                logic [7:0] e;
                e = exp_tx.pop_front();
                if (tx_char !== e) begin
                    errors++;
                    $display("FAIL tx_byte got %02h required %02h", tx_char, e);
                end else begin
                    $display("tx byte %02h ok", tx_char);
                end
            end
        end
        tx_rdy = tx_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Memory side: checks each request against the model, its stability and duration; drives ack.
    bit    req_prev = 0;
    int    hi_cnt = 0;
    bit    stab_bad = 0;
    logic [36:0] cap;
    always @(negedge clk) begin
        if (mem_req && !req_prev) begin
            hi_cnt   = 0;
            stab_bad = 0;
            cap      = {mem_rw, mem_adr, mem_dtw};
            checks++;
            if (exp_mem.size() == 0) begin
                errors++;
                $display("FAIL mem_unexpected got rw=%0b adr=%05h", mem_rw, mem_adr);
            end else begin
                mreq_t r;
                r = exp_mem.pop_front();
                if (mem_rw !== r.rw || mem_adr !== r.adr || (r.rw && mem_dtw !== r.dtw)) begin
                    errors++;
                    $display("FAIL mem_req got rw=%0b adr=%05h dtw=%04h required rw=%0b adr=%05h dtw=%04h",
                             mem_rw, mem_adr, mem_dtw, r.rw, r.adr, r.dtw);
                end else begin
                    $display("mem req rw=%0b adr=%05h dtw=%04h ok", mem_rw, mem_adr, mem_dtw);
                end
            end
        end
        if (mem_req) begin
            hi_cnt++;
            if ({mem_rw, mem_adr, mem_dtw} !== cap) stab_bad = 1;
        end
        if (!mem_req && req_prev) begin
            checks++;
            if (stab_bad) begin
                errors++;
                $display("FAIL mem_stable got changing fields required stable while mem_req=1");
            end
            if (!skip_hi) begin
                int e;
                e = (ack_delay > 0) ? ack_delay : 255;
                checks++;
                if (hi_cnt != e) begin
                    errors++;
                    $display("FAIL mem_req_len got %0d required %0d", hi_cnt, e);
                end
            end
        end
        mem_ack = 1'b0;
        mem_dtr = 16'($urandom);
        if (mem_req && ack_delay > 0 && hi_cnt == ack_delay) begin
            mem_ack = 1'b1;
            mem_dtr = rd_val;
        end
        if (force_ack) mem_ack = 1'b1;
        req_prev = mem_req;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_new  = 1'b1;
        @(negedge clk);
        rx_new  = 1'b0;
        rx_data = 8'($urandom);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %0h required %0h", name, got, req);
        end
    endtask

    task automatic wait_req(input logic lvl, input string tag);
        int n = 0;
        while (mem_req !== lvl && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 1000) begin
            errors++;
            $display("FAIL %s_wait_req got mem_req=%0b required %0b", tag, mem_req, lvl);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || exp_tx.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL %s_idle got busy=%0b pending=%0d required idle", tag, busy, exp_tx.size());
        end
        repeat (3) @(negedge clk);
        check_val({tag, "_busy_after"}, 32'(busy), 32'd0);
        check_val({tag, "_mem_pending"}, 32'(exp_mem.size()), 32'd0);
    endtask

    // junk: 0 none, 1 extra bytes while the request is open, 2 extra bytes during the response.
    task automatic do_txn(input logic [7:0] cmd, input logic [19:0] adr, input logic [15:0] dat,
                          input int dly, input int junk, input string tag);
        logic [7:0] a2;
        mreq_t      r;
        bit         is_n;
        is_n = 0;
`ifdef PROG_SEQ_AUTOINC_EN
        is_n = (cmd == 8'h6E);
`endif
        ack_delay = dly;
        rd_val    = 16'($urandom);
        a2        = 8'($urandom);
        a2[3:0]   = adr[19:16];
        if (junk == 2) tx_hold = 1;
        if (cmd == 8'h72 || cmd == 8'h77 || is_n) begin
            r.rw  = (cmd != 8'h72);
            r.adr = is_n ? mdl_last + 20'd1 : adr;
            r.dtw = dat;
            exp_mem.push_back(r);
            if (dly <= 0) begin
                exp_tx.push_back(8'h21);
            end else begin
                mdl_last = r.adr;
                if (r.rw) begin
                    exp_tx.push_back(8'h77);
                end else begin
                    exp_tx.push_back(rd_val[15:8]);
                    exp_tx.push_back(rd_val[7:0]);
                end
            end
            send_byte(cmd);
            check_val({tag, "_busy"}, 32'(busy), 32'd1);
            if (!is_n) begin
                send_byte(a2);
                send_byte(adr[15:8]);
                send_byte(adr[7:0]);
            end
            if (r.rw) begin
                send_byte(dat[15:8]);
                send_byte(dat[7:0]);
            end
            if (junk == 1) begin
                wait_req(1'b1, tag);
                send_byte(8'h12);
                send_byte(8'h34);
            end
            if (junk == 2) begin
                wait_req(1'b1, tag);
                wait_req(1'b0, tag);
                send_byte(8'h77);
                send_byte(8'h41);
                send_byte(8'h72);
                tx_hold = 0;
            end
        end else begin
            exp_tx.push_back(8'h3F);
            send_byte(cmd);
            tx_hold = 0;
        end
        wait_idle(tag);
        $display("txn %s cmd=%02h adr=%05h dat=%04h dly=%0d done", tag, cmd, adr, dat, dly);
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_mem_req", 32'(mem_req), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_tx_new", 32'(tx_new), 32'd0);
        check_val("rst_tx_char", 32'(tx_char), 32'd0);
        check_val("rst_mem_fields", {11'd0, mem_rw, mem_adr}, 32'd0);
        check_val("rst_mem_dtw", 32'(mem_dtw), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_txn(8'h72, 20'h01234, 16'h0000, 3, 0, "read_beef");
        do_txn(8'h77, 20'hFFFFF, 16'hA55A, 2, 0, "write_fffff");
`ifdef PROG_SEQ_AUTOINC_EN
        do_txn(8'h6E, 20'h00000, 16'h1122, 4, 0, "autoinc_wrap");
`else
        do_txn(8'h6E, 20'h00000, 16'h0000, 1, 0, "n_unknown");
`endif
        do_txn(8'h41, 20'h00000, 16'h0000, 1, 0, "unknown_41");
        do_txn(8'h72, 20'h0ABCD, 16'h0000, 0, 0, "read_timeout");
        do_txn(8'h77, 20'h54321, 16'h7E7E, 255, 0, "ack_at_255");
        do_txn(8'h72, 20'h00F0F, 16'h0000, 40, 1, "rx_in_req");
        do_txn(8'h72, 20'h33333, 16'h0000, 10, 2, "rx_in_rsp");

        // Reset while the request is open; a late ack must not produce a response.
        begin
            mreq_t r;
            r.rw = 0; r.adr = 20'h0BEEF; r.dtw = 16'd0;
            exp_mem.push_back(r);
            ack_delay = 0;
            skip_hi   = 1;
            send_byte(8'h72);
            send_byte(8'h00);
            send_byte(8'hBE);
            send_byte(8'hEF);
            wait_req(1'b1, "rst_req");
            repeat (5) @(negedge clk);
            seen = tx_seen;
            rst = 1'b1;
            @(negedge clk);
            check_val("rst_mid_mem_req", 32'(mem_req), 32'd0);
            check_val("rst_mid_busy", 32'(busy), 32'd0);
            check_val("rst_mid_adr", 32'(mem_adr), 32'd0);
            rst = 1'b0;
            mdl_last = 20'd0;
            @(negedge clk);
            force_ack = 1;
            @(negedge clk);
            force_ack = 0;
            repeat (30) @(negedge clk);
            check_val("rst_late_ack_tx", 32'(tx_seen), 32'(seen));
            check_val("rst_late_ack_busy", 32'(busy), 32'd0);
            skip_hi = 0;
        end

        for (int i = 0; i < 30; i++) begin
            int          kind;
            int          dly;
            logic [7:0]  cmd;
            kind = $urandom_range(0, 8);
            dly  = (i == 7) ? 255 : $urandom_range(1, 20);
            if (i % 10 == 9) begin
                kind = 0;
                dly  = 0;
            end
            case (kind)
                0, 1, 2, 3: cmd = 8'h72;
                4, 5, 6:    cmd = 8'h77;
                7:          cmd = 8'h6E;
                default: begin
                    cmd = 8'($urandom);
                    if (cmd == 8'h72 || cmd == 8'h77 || cmd == 8'h6E) cmd = 8'h00;
                end
            endcase
            do_txn(cmd, 20'($urandom), 16'($urandom), dly, 0, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running required finished");
        $fatal(1, "timeout");
    end

endmodule
